// File: rtl/display_pkg.sv
// Shared constants, FSM state type and segment LUT for the n-digit display driver.
// Segment encodings are active-low gfedcba.
package display_pkg;

  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} conv_state_t;

  function automatic logic [6:0] seg_hex(input logic [3:0] n);
    case (n)
      4'h0: seg_hex = 7'h40;
      4'h1: seg_hex = 7'h79;
      4'h2: seg_hex = 7'h24;
      4'h3: seg_hex = 7'h30;
      4'h4: seg_hex = 7'h19;
      4'h5: seg_hex = 7'h12;
      4'h6: seg_hex = 7'h02;
      4'h7: seg_hex = 7'h78;
      4'h8: seg_hex = 7'h00;
      4'h9: seg_hex = 7'h10;
      4'hA: seg_hex = 7'h08;
      4'hB: seg_hex = 7'h03;
      4'hC: seg_hex = 7'h46;
      4'hD: seg_hex = 7'h21;
      4'hE: seg_hex = 7'h06;
      default: seg_hex = 7'h0E;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one step per clock. The first step is folded
// into the start cycle so a full conversion completes DATA_W edges after start.
module bin2bcd_seq #(
  parameter int DATA_W = 16,
  parameter int DIGITS = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   start,
  input  logic [DATA_W-1:0]      bin,
  output logic                   busy,
  output logic                   done,
  output logic [DIGITS-1:0][3:0] bcd,
  output logic                   ovf
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]      sh;
  logic [CW-1:0]          cnt;
  logic [DIGITS-1:0][3:0] src, adj, nxt;
  logic                   in_bit, cout;

  always_comb begin
    src    = start ? '0 : bcd;
    in_bit = start ? bin[DATA_W-1] : sh[DATA_W-1];
    for (int i = 0; i < DIGITS; i++)
      adj[i] = (src[i] >= 4'd5) ? src[i] + 4'd3 : src[i];
    // cout is the bit pushed out of the top nibble: value too wide for DIGITS
    {cout, nxt} = {adj, in_bit};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sh   <= '0;
      cnt  <= '0;
      bcd  <= '0;
      ovf  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bcd  <= nxt;
        sh   <= bin << 1;
        cnt  <= CW'(DATA_W - 1);
        ovf  <= cout;
        done <= (DATA_W == 1);
      end else if (cnt != '0) begin
        bcd  <= nxt;
        sh   <= sh << 1;
        cnt  <= cnt - 1'b1;
        ovf  <= ovf | cout;
        done <= (cnt == CW'(1));
      end
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/display_scan_ndigit.sv
// Multiplexed common-anode seven-segment driver: hex or decimal conversion,
// atomic frame update, leading-zero blanking, per-digit minus and decimal point.
module display_scan_ndigit
  import display_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int DATA_W   = 16,
  parameter int SCAN_DIV = 100000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] x,
  input  logic              mode,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] neg,
  input  logic [DIGITS-1:0] dp,
  output logic [DIGITS+7:0] DISP
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIGITS);

  typedef struct packed {
    logic [DIGITS-1:0][3:0] dig;
    logic                   ovf;
    logic                   dec;
  } frame_t;

  conv_state_t            state, state_nxt;
  logic                   cap, eng_start, wr;
  logic [DATA_W-1:0]      x_q;
  logic                   mode_q;
  logic                   eng_busy, eng_done, eng_ovf;
  logic [DIGITS-1:0][3:0] eng_bcd;
  logic [4*DIGITS-1:0]    hex_flat;
  frame_t                 frm;
  logic [PW-1:0]          presc;
  logic [IW-1:0]          idx;
  logic                   hi_zero;
  logic [6:0]             seg;
  logic [DIGITS-1:0]      an;

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = mode ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (eng_done) state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cap       = (state == ST_IDLE);
    eng_start = cap & mode & ~eng_busy;
    wr        = (state == ST_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      x_q    <= '0;
      mode_q <= 1'b0;
    end else if (cap) begin
      x_q    <= x;
      mode_q <= mode;
    end
  end

  bin2bcd_seq #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_bcd (
    .CLK   (CLK),
    .RST   (RST),
    .start (eng_start),
    .bin   (x),
    .busy  (eng_busy),
    .done  (eng_done),
    .bcd   (eng_bcd),
    .ovf   (eng_ovf)
  );

  always_comb begin
    hex_flat              = '0;
    hex_flat[DATA_W-1:0]  = x_q;
  end

  // digits, overflow and mode switch together so no partial frame is shown
  always_ff @(posedge CLK) begin
    if (RST) begin
      frm <= '0;
    end else if (wr) begin
      frm.dig <= mode_q ? eng_bcd : hex_flat;
      frm.ovf <= mode_q & eng_ovf;
      frm.dec <= mode_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_comb begin
    hi_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++)
      if (j >= int'(idx)) hi_zero &= (frm.dig[j] == 4'd0);
    if (neg[idx])                            seg = SEG_MINUS;
    else if (frm.dec && frm.ovf)             seg = SEG_MINUS;
    else if (blank_lz && idx != '0 && hi_zero) seg = SEG_BLANK;
    else                                     seg = seg_hex(frm.dig[idx]);
    an      = '1;
    an[idx] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) DISP <= '1;
    else     DISP <= {an, ~dp[idx], seg};
  end

endmodule

// File: tb/tb_display_scan_ndigit.sv
// Self-checking bench: a digit-level reference model pushes expected DISP words into a
// queue once inputs have settled; each scenario pops and compares one word per scan cycle.
module tb_display_scan_ndigit;

  localparam int DIGITS   = 4;
  localparam int DATA_W   = 16;
  localparam int SCAN_DIV = 1;
  localparam int SETTLE   = 2 * (DATA_W + 2) + 5;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] x = '0;
  logic        mode = 1'b0, blank_lz = 1'b0;
  logic [3:0]  neg = '0, dp = '0;
  logic [11:0] DISP;

  always #5 CLK = ~CLK;

  display_scan_ndigit #(.DIGITS(DIGITS), .DATA_W(DATA_W), .SCAN_DIV(SCAN_DIV)) dut (
    .CLK(CLK), .RST(RST), .x(x), .mode(mode), .blank_lz(blank_lz),
    .neg(neg), .dp(dp), .DISP(DISP)
  );

  int checks = 0, errors = 0;
  int nxt = 0, shown = -1;
  int m_val = 0;
  logic m_mode = 1'b0, m_blank = 1'b0;
  logic [3:0] m_neg = '0, m_dp = '0;
  logic [11:0] exp_q[$];
  logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // one clock; tracks which digit the DISP word sampled after this edge belongs to
  task automatic tick();
    logic r;
    r = RST;
    @(posedge CLK);
    #1;
    if (r) begin shown = -1; nxt = 0; end
    else begin shown = nxt; nxt = (nxt + 1) % DIGITS; end
  endtask

  task automatic set_in(input int val, input logic md, input logic bl,
                        input logic [3:0] ng, input logic [3:0] dpv);
    x = val[15:0]; mode = md; blank_lz = bl; neg = ng; dp = dpv;
    m_val = val; m_mode = md; m_blank = bl; m_neg = ng; m_dp = dpv;
  endtask

  function automatic logic [11:0] model(input int i);
    int base, p, d;
    logic [6:0] s;
    logic [3:0] a;
    base = m_mode ? 10 : 16;
    p = 1;
    for (int k = 0; k < i; k++) p = p * base;
    d = (m_val / p) % base;
    if (m_neg[i])                        s = 7'h3F;
    else if (m_mode && m_val > 9999)     s = 7'h3F;
    else if (m_blank && i > 0 && m_val < p) s = 7'h7F;
    else                                 s = lut[d];
    a = 4'hF;
    a[i] = 1'b0;
    return {a, ~m_dp[i], s};
  endfunction

  function automatic void expect_frames(input int n);
    for (int k = 0; k < n * DIGITS; k++) exp_q.push_back(model((nxt + k) % DIGITS));
  endfunction

  task automatic test_reset();
    logic [11:0] e;
    RST = 1'b1;
    set_in(0, 1'b0, 1'b0, 4'h0, 4'h0);
    tick(); tick();
    checks++;
    if (DISP !== 12'hFFF) begin
      errors++; $display("FAIL reset_hold got=%h exp=fff", DISP);
    end
    RST = 1'b0;
    expect_frames(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tick(); checks++;
      if (DISP !== e) begin errors++; $display("FAIL reset_walk idx=%0d got=%h exp=%h", shown, DISP, e); end
    end
  endtask

  task automatic test_hex();
    logic [11:0] e;
    set_in(32'h1A2F, 1'b0, 1'b0, 4'h0, 4'h0);
    repeat (SETTLE) tick();
    expect_frames(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tick(); checks++;
      if (DISP !== e) begin errors++; $display("FAIL hex_1a2f idx=%0d got=%h exp=%h", shown, DISP, e); end
    end
  endtask

  task automatic test_decimal();
    logic [11:0] e;
    int vals [2] = '{1234, 9999};
    foreach (vals[v]) begin
      set_in(vals[v], 1'b1, 1'b0, 4'h0, 4'h0);
      repeat (SETTLE) tick();
      expect_frames(2);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); tick(); checks++;
        if (DISP !== e) begin errors++; $display("FAIL dec_%0d idx=%0d got=%h exp=%h", vals[v], shown, DISP, e); end
      end
    end
  endtask

  task automatic test_overflow_blank();
    logic [11:0] e;
    set_in(10000, 1'b1, 1'b0, 4'h0, 4'h0);
    repeat (SETTLE) tick();
    expect_frames(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tick(); checks++;
      if (DISP !== e) begin errors++; $display("FAIL dec_ovf idx=%0d got=%h exp=%h", shown, DISP, e); end
    end
    set_in(5, 1'b1, 1'b1, 4'h0, 4'h0);
    repeat (SETTLE) tick();
    expect_frames(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tick(); checks++;
      if (DISP !== e) begin errors++; $display("FAIL dec_blank5 idx=%0d got=%h exp=%h", shown, DISP, e); end
    end
  endtask

  task automatic test_neg_dp();
    logic [11:0] e;
    set_in(0, 1'b0, 1'b1, 4'h0, 4'h0);
    repeat (SETTLE) tick();
    expect_frames(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tick(); checks++;
      if (DISP !== e) begin errors++; $display("FAIL hex_zero_blank idx=%0d got=%h exp=%h", shown, DISP, e); end
    end
    set_in(32'h0123, 1'b0, 1'b1, 4'b1000, 4'b0001);
    repeat (SETTLE) tick();
    expect_frames(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tick(); checks++;
      if (DISP !== e) begin errors++; $display("FAIL neg_dp idx=%0d got=%h exp=%h", shown, DISP, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] e;
    set_in(1234, 1'b1, 1'b0, 4'h0, 4'h0);
    repeat (SETTLE) tick();
    expect_frames(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tick(); checks++;
      if (DISP !== e) begin errors++; $display("FAIL mid_pre idx=%0d got=%h exp=%h", shown, DISP, e); end
    end
    x = 16'd4321;
    repeat (3) tick();
    for (int k = 0; k < 2 * DIGITS && shown != 2; k++) tick();
    checks++;
    if (shown != 2) begin errors++; $display("FAIL mid_find_an2 got=%0d exp=2", shown); end
    RST = 1'b1;
    tick();
    checks++;
    if (DISP !== 12'hFFF) begin errors++; $display("FAIL mid_reset got=%h exp=fff", DISP); end
    RST = 1'b0;
    m_val = 0; m_mode = 1'b0;
    expect_frames(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tick(); checks++;
      if (DISP !== e) begin errors++; $display("FAIL mid_restart idx=%0d got=%h exp=%h", shown, DISP, e); end
    end
    m_val = 4321; m_mode = 1'b1;
    repeat (SETTLE) tick();
    expect_frames(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tick(); checks++;
      if (DISP !== e) begin errors++; $display("FAIL mid_4321 idx=%0d got=%h exp=%h", shown, DISP, e); end
    end
  endtask

  initial begin
    test_reset();
    test_hex();
    test_decimal();
    test_overflow_blank();
    test_neg_dp();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
